// File: rtl/irq_capture.sv
// ---------------------------------------------------------------------------
// irq_capture
//
// Request-capture stage in front of the priority encoder. Each request line is
// synchronised through two flops. In edge mode (EDGE=1) a rising edge sets a
// sticky pending bit, which stays set until the consumer acknowledges it by
// index. If a source fires again while its bit is still pending, the new event
// is folded into the existing one and a sticky overflow flag records the loss.
// In level mode (EDGE=0) the pending bits follow the synchronised levels, and
// ack has no effect.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset (clears all state)
//   irq_in    [N]  raw asynchronous request lines
//   mask      [N]  1 = hide that source at the output (capture continues)
//   ack       acknowledge strobe, one cycle
//   ack_idx   [IW] index of the pending bit to clear; values >= N are ignored
//   pending   [N]  pending & ~mask, feeds the encoder
//   req       OR of pending
//   overflow  [N]  sticky lost-request flags
//   clr_ovf   clears all overflow flags (a new overflow in the same cycle wins)
// ---------------------------------------------------------------------------
module irq_capture #(
   parameter int N    = 4,
   parameter bit EDGE = 1'b1,
   parameter int IW   = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  irq_in,
   input  logic [N-1:0]  mask,
   input  logic          ack,
   input  logic [IW-1:0] ack_idx,
   output logic [N-1:0]  pending,
   output logic          req,
   output logic [N-1:0]  overflow,
   input  logic          clr_ovf
);

   logic [N-1:0] r_sync1;
   logic [N-1:0] r_sync2;
   logic [N-1:0] r_prev;
   logic [N-1:0] r_pend;
   logic [N-1:0] r_ovf;

   logic [N-1:0] w_edge;
   logic [N-1:0] w_ack_hit;
   logic [N-1:0] w_pend_nxt;
   logic [N-1:0] w_ovf_nxt;

   always_comb begin
      // r_prev resets to 0, so a line held high through reset yields one edge.
      w_edge    = r_sync2 & ~r_prev;

      // Decode the ack to a one-hot clear mask. Indices >= N match no bit.
      w_ack_hit = '0;
      for (int i = 0; i < N; i++) begin
         if (ack && (ack_idx == IW'(i))) begin
            w_ack_hit[i] = 1'b1;
         end
      end

      if (EDGE) begin
         // Set wins over clear, so an event arriving with its own ack is kept.
         w_pend_nxt = w_edge | (r_pend & ~w_ack_hit);
         // An edge on a bit that is still pending (and not being acked right
         // now) loses a request. A set takes priority over clr_ovf.
         w_ovf_nxt  = (w_edge & r_pend & ~w_ack_hit) | (r_ovf & ~{N{clr_ovf}});
      end else begin
         w_pend_nxt = r_sync2;
         w_ovf_nxt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
         r_pend  <= '0;
         r_ovf   <= '0;
      end else begin
         r_sync1 <= irq_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_pend  <= w_pend_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   // Masking is applied only at the output, so unmasking exposes a held
   // request in the same cycle.
   assign pending  = r_pend & ~mask;
   assign req      = |pending;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_irq_capture.sv
// ---------------------------------------------------------------------------
// tb_irq_capture
//
// Directed bench for irq_capture. One instance runs in edge mode and a second
// runs in level mode; both share all inputs. Inputs change 1 time unit after
// each rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_irq_capture;

   logic       clk;
   logic       rst;
   logic [3:0] irq_in;
   logic [3:0] mask;
   logic       ack;
   logic [1:0] ack_idx;
   logic       clr_ovf;

   logic [3:0] pend_e, ovf_e, pend_l, ovf_l;
   logic       req_e, req_l;

   int errors = 0;
   int checks = 0;

   irq_capture #(.N(4), .EDGE(1'b1)) dut_e (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .ack(ack),
      .ack_idx(ack_idx), .pending(pend_e), .req(req_e), .overflow(ovf_e),
      .clr_ovf(clr_ovf)
   );

   irq_capture #(.N(4), .EDGE(1'b0)) dut_l (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .ack(ack),
      .ack_idx(ack_idx), .pending(pend_l), .req(req_l), .overflow(ovf_l),
      .clr_ovf(clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; irq_in = 4'b0000; mask = 4'b0000;
      ack = 1'b0; ack_idx = 2'd0; clr_ovf = 1'b0;
      step(2);
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b exp %b", pend_e, 4'b0000); end
      checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp %b", req_e, 1'b0); end
      checks++; if (ovf_e !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b exp %b", ovf_e, 4'b0000); end
      checks++; if (pend_l !== 4'b0000) begin errors++; $display("FAIL reset_pend_l: got %b exp %b", pend_l, 4'b0000); end
      rst = 1'b0; irq_in = 4'b0100;
      step(1);
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL single_e0: got %b exp %b", pend_e, 4'b0000); end
      step(1);
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL single_e1: got %b exp %b", pend_e, 4'b0000); end
      step(1);
      checks++; if (pend_e !== 4'b0100) begin errors++; $display("FAIL single_e2: got %b exp %b", pend_e, 4'b0100); end
      checks++; if (req_e !== 1'b1) begin errors++; $display("FAIL single_req: got %b exp %b", req_e, 1'b1); end
      ack = 1'b1; ack_idx = 2'd2;
      step(1);
      ack = 1'b0;
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL single_ack: got %b exp %b", pend_e, 4'b0000); end
      checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL single_ack_req: got %b exp %b", req_e, 1'b0); end
      irq_in = 4'b0000;
      step(3);
   endtask

   task automatic test_mask;
      irq_in = 4'b1001; mask = 4'b1000;
      step(3);
      checks++; if (pend_e !== 4'b0001) begin errors++; $display("FAIL mask_pend: got %b exp %b", pend_e, 4'b0001); end
      checks++; if (req_e !== 1'b1) begin errors++; $display("FAIL mask_req: got %b exp %b", req_e, 1'b1); end
      mask = 4'b0000;
      #1;
      checks++; if (pend_e !== 4'b1001) begin errors++; $display("FAIL unmask_pend: got %b exp %b", pend_e, 4'b1001); end
      ack = 1'b1; ack_idx = 2'd3;
      step(1);
      checks++; if (pend_e !== 4'b0001) begin errors++; $display("FAIL ack3: got %b exp %b", pend_e, 4'b0001); end
      ack_idx = 2'd0;
      step(1);
      ack = 1'b0;
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL ack0: got %b exp %b", pend_e, 4'b0000); end
      checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL ack0_req: got %b exp %b", req_e, 1'b0); end
      irq_in = 4'b0000;
      step(3);
   endtask

   task automatic test_collision;
      irq_in = 4'b0010;
      step(3);
      checks++; if (pend_e !== 4'b0010) begin errors++; $display("FAIL coll_setup: got %b exp %b", pend_e, 4'b0010); end
      irq_in = 4'b0000;
      step(3);
      irq_in = 4'b0010;
      step(2);
      // the second edge is now presented; ack the same bit in this cycle
      ack = 1'b1; ack_idx = 2'd1;
      step(1);
      ack = 1'b0;
      checks++; if (pend_e !== 4'b0010) begin errors++; $display("FAIL coll_pend: got %b exp %b", pend_e, 4'b0010); end
      checks++; if (ovf_e !== 4'b0000) begin errors++; $display("FAIL coll_ovf: got %b exp %b", ovf_e, 4'b0000); end
      ack = 1'b1; ack_idx = 2'd1;
      step(1);
      ack = 1'b0;
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL coll_clean: got %b exp %b", pend_e, 4'b0000); end
      irq_in = 4'b0000;
      step(3);
   endtask

   task automatic test_overflow;
      irq_in = 4'b0100;
      step(3);
      irq_in = 4'b0000;
      step(3);
      irq_in = 4'b0100;
      step(3);
      checks++; if (ovf_e !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b exp %b", ovf_e, 4'b0100); end
      step(2);
      checks++; if (ovf_e !== 4'b0100) begin errors++; $display("FAIL ovf_sticky: got %b exp %b", ovf_e, 4'b0100); end
      checks++; if (pend_e !== 4'b0100) begin errors++; $display("FAIL ovf_pend: got %b exp %b", pend_e, 4'b0100); end
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      checks++; if (ovf_e !== 4'b0000) begin errors++; $display("FAIL ovf_clr: got %b exp %b", ovf_e, 4'b0000); end
      irq_in = 4'b0000;
      step(3);
      irq_in = 4'b0100;
      step(2);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      checks++; if (ovf_e !== 4'b0100) begin errors++; $display("FAIL ovf_set_wins: got %b exp %b", ovf_e, 4'b0100); end
      ack = 1'b1; ack_idx = 2'd2; clr_ovf = 1'b1;
      step(1);
      ack = 1'b0; clr_ovf = 1'b0;
      checks++; if ({pend_e, ovf_e} !== 8'h00) begin errors++; $display("FAIL ovf_clean: got %h exp %h", {pend_e, ovf_e}, 8'h00); end
      irq_in = 4'b0000;
      step(3);
   endtask

   task automatic test_level;
      irq_in = 4'b0011;
      step(2);
      checks++; if (pend_l !== 4'b0000) begin errors++; $display("FAIL lvl_early: got %b exp %b", pend_l, 4'b0000); end
      step(1);
      checks++; if (pend_l !== 4'b0011) begin errors++; $display("FAIL lvl_pend: got %b exp %b", pend_l, 4'b0011); end
      checks++; if (req_l !== 1'b1) begin errors++; $display("FAIL lvl_req: got %b exp %b", req_l, 1'b1); end
      ack = 1'b1; ack_idx = 2'd0;
      step(1);
      ack = 1'b0;
      checks++; if (pend_l !== 4'b0011) begin errors++; $display("FAIL lvl_ack: got %b exp %b", pend_l, 4'b0011); end
      irq_in = 4'b0000;
      step(2);
      checks++; if (pend_l !== 4'b0011) begin errors++; $display("FAIL lvl_hold: got %b exp %b", pend_l, 4'b0011); end
      step(1);
      checks++; if (pend_l !== 4'b0000) begin errors++; $display("FAIL lvl_drop: got %b exp %b", pend_l, 4'b0000); end
      checks++; if (ovf_l !== 4'b0000) begin errors++; $display("FAIL lvl_ovf: got %b exp %b", ovf_l, 4'b0000); end
   endtask

   task automatic test_reset_mid;
      // the edge-mode instance picked up bits 0 and 1 during the level test
      ack = 1'b1; ack_idx = 2'd0; clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0; ack_idx = 2'd1;
      step(1);
      ack = 1'b0;
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL mid_clean: got %b exp %b", pend_e, 4'b0000); end
      irq_in = 4'b1010;
      step(3);
      irq_in = 4'b1000;
      step(3);
      irq_in = 4'b1010;
      step(3);
      checks++; if (pend_e !== 4'b1010) begin errors++; $display("FAIL mid_pend: got %b exp %b", pend_e, 4'b1010); end
      checks++; if (ovf_e !== 4'b0010) begin errors++; $display("FAIL mid_ovf: got %b exp %b", ovf_e, 4'b0010); end
      irq_in = 4'b1000; rst = 1'b1;
      step(1);
      rst = 1'b0;
      checks++; if ({pend_e, ovf_e, req_e} !== 9'h000) begin errors++; $display("FAIL mid_rst_e: got %h exp %h", {pend_e, ovf_e, req_e}, 9'h000); end
      checks++; if ({pend_l, ovf_l, req_l} !== 9'h000) begin errors++; $display("FAIL mid_rst_l: got %h exp %h", {pend_l, ovf_l, req_l}, 9'h000); end
      step(1);
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL recap_e1: got %b exp %b", pend_e, 4'b0000); end
      step(1);
      checks++; if (pend_e !== 4'b0000) begin errors++; $display("FAIL recap_e2: got %b exp %b", pend_e, 4'b0000); end
      step(1);
      checks++; if (pend_e !== 4'b1000) begin errors++; $display("FAIL recap_e3: got %b exp %b", pend_e, 4'b1000); end
      checks++; if (pend_l !== 4'b1000) begin errors++; $display("FAIL recap_l3: got %b exp %b", pend_l, 4'b1000); end
      step(3);
      checks++; if (pend_e !== 4'b1000) begin errors++; $display("FAIL recap_hold: got %b exp %b", pend_e, 4'b1000); end
      checks++; if (ovf_e !== 4'b0000) begin errors++; $display("FAIL recap_once: got %b exp %b", ovf_e, 4'b0000); end
   endtask

   initial begin
      test_reset();
      test_mask();
      test_collision();
      test_overflow();
      test_level();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_capture.md
Name: irq_capture

Overview:
- Request-capture stage that sits directly upstream of the 4-input priority encoder and drives its request vector.
- Synchronises N asynchronous request lines and detects rising edges (or samples levels).
- Holds each request as a sticky pending bit until the consumer acknowledges it by index.
- Flags requests lost because their source fired again while still pending.

Parameters:
- N, 4, number of request sources. Matches the 4-bit encoder input; legal range 2..16.
- EDGE, 1, capture mode. 1 = rising-edge triggered (sticky); 0 = level-sensitive (pending tracks synchronised level, ack ignored).
- IW, $clog2(N), index width for ack_idx (2 at default).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  N  raw asynchronous request lines.
- mask  input  N  1 = source masked at output. Synchronous to clk.
- ack  input  1  acknowledge strobe, one cycle.
- ack_idx  input  IW  index of the pending bit to clear when ack=1. Normally the encoder's output.
- pending  output  N  pending & ~mask. Feeds encoder input directly.
- req  output  1  OR-reduction of pending.
- overflow  output  N  sticky per-source lost-request flag.
- clr_ovf  input  1  clears all overflow bits.

Behaviour:
- Reset: while rst=1 at a clock edge, the following all clear to 0: sync1, sync2, prev, pending_q and overflow. Outputs are therefore 0 in the cycle after the reset edge. Reset mid-operation discards all pending and overflow state with no acknowledgement required.
- Synchronizer: per bit, sync1 <= irq_in, sync2 <= sync1, prev <= sync2.
- Edge detect: edge = sync2 & ~prev, combinational. prev resets to 0, so a line held high through reset produces exactly one edge after reset.
- Latency, EDGE=1: irq_in high before edge 0, then sync2=1 after edge 1, then pending_q=1 after edge 2. pending/req are visible 3 edges after input assertion. Pulses narrower than one clk period may be missed, by definition.
- pending_q update per bit i, EDGE=1:
  - set if edge[i];
  - else clear if ack && ack_idx==i;
  - else hold.
  - Simultaneous edge and ack on the same bit: set wins, so the new event is kept.
- ack_idx >= N: ack is ignored, nothing clears.
- ack on a bit that is already 0: no effect, no error.
- ack on a masked bit: the pending_q bit still clears.
- EDGE=0: pending_q <= sync2 every cycle; ack is ignored; overflow never sets.
- Mask: applies at the output only. Capture continues while masked; unmasking a bit with pending_q=1 makes pending rise combinationally in the same cycle.
- Overflow per bit i:
  - set when edge[i] && pending_q[i] && !(ack && ack_idx==i);
  - else clear when clr_ovf;
  - set wins over clr_ovf in the same cycle.
- req = |pending, combinational from registers and mask. There is no combinational path from irq_in.
- Multiple simultaneous edges: all corresponding bits set in one cycle; prioritisation is left to the encoder.
- Acks in consecutive cycles are all honoured. Exactly one bit can be cleared per cycle.
- Widths: all vectors are N bits. ack_idx is compared zero-extended to the bit index.

Test Plan:
- Reset then single edge: rst 1 for 2 cycles; irq_in=4'b0100 before edge 0. Required: pending=4'b0000 through edge 1, pending=4'b0100 and req=1 after edge 2. After ack=1, ack_idx=2 for one cycle, pending=4'b0000 and req=0 on the next edge.
- Multi-source with mask: edges on bits 0 and 3, mask=4'b1000. Required: pending=4'b0001 and req=1. After mask changes to 0, pending=4'b1001 in the same cycle. ack idx 3 then idx 0 on consecutive cycles gives 4'b0001, then 4'b0000.
- Set/clear collision: bit 1 pending; new edge on bit 1 in the same cycle as ack idx 1. Required: pending[1] stays 1 and overflow[1] stays 0.
- Overflow: bit 2 pending, no ack, second rising edge on irq_in[2]. Required: overflow=4'b0100, sticky. A clr_ovf pulse returns it to 4'b0000. clr_ovf coincident with a fresh overflow edge leaves it at 4'b0100.
- Level mode (EDGE=0): irq_in=4'b0011 held. Required: pending=4'b0011 after 3 edges; ack idx 0 has no effect; after irq_in=0, pending=0 three edges later; overflow stays 0.
- Reset mid-operation and held line: pending=4'b1010 and overflow=4'b0010; irq_in[3] held high; rst pulse for 1 cycle. Required: all outputs 0 after the reset edge. pending=4'b1000 is re-captured exactly once, 3 edges after rst deasserts. Out-of-range or absent ack produces no other change.
